// File: rtl/shift_sched.sv
// Shared-shifter scheduler: arbitrates two requesters onto one iterative shifter,
// clamping wide shift amounts and returning tagged results over valid/ready.
module shift_sched #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 36,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic [AMT_W-1:0] a_amt,
  input  logic [1:0]       a_op,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic [AMT_W-1:0] b_amt,
  input  logic [1:0]       b_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic [7:0]       done_cnt
);

  localparam int REM_W = $clog2(WIDTH + 1);
  localparam logic [REM_W-1:0] WIDTH_REM = REM_W'(WIDTH);
  localparam logic [REM_W-1:0] STEP_REM  = REM_W'(STEP);
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               last_grant_r;
  logic               grant_s;
  logic               accept_s;
  logic               res_hs_s;
  logic [1:0]         op_r;
  logic               sign_r;
  logic [REM_W-1:0]   rem_r;
  logic [REM_W-1:0]   step_s;
  logic [REM_W-1:0]   rem_nxt_s;
  logic [REM_W-1:0]   eff_s;
  logic [WIDTH-1:0]   sel_data_s;
  logic [AMT_W-1:0]   sel_amt_s;
  logic [1:0]         sel_op_s;
  logic [WIDTH-1:0]   fill_s;
  logic [WIDTH-1:0]   work_nxt_s;

  // Round-robin grant and operand selection for the winning requester
  always_comb begin
    grant_s = 1'b0;
    if (a_valid && b_valid) begin
      grant_s = ~last_grant_r;
    end else if (b_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    sel_data_s = grant_s ? b_data : a_data;
    sel_amt_s  = grant_s ? b_amt  : a_amt;
    sel_op_s   = grant_s ? b_op   : a_op;
    // Compare the full-width amount so huge values with zero low bits still clamp
    if (sel_op_s == 2'b11) begin
      eff_s = {REM_W{1'b0}};
    end else if (sel_amt_s >= WIDTH_AMT) begin
      eff_s = WIDTH_REM;
    end else begin
      eff_s = sel_amt_s[REM_W-1:0];
    end
  end

  assign a_ready  = rst_n & (state_r == IDLE) & a_valid & ~grant_s;
  assign b_ready  = rst_n & (state_r == IDLE) & b_valid & grant_s;
  assign accept_s = a_ready | b_ready;
  assign res_hs_s = (state_r == DONE) & res_ready;

  // One shift step of at most STEP bits; ASR fills from the captured sign
  always_comb begin
    step_s     = (rem_r < STEP_REM) ? rem_r : STEP_REM;
    rem_nxt_s  = rem_r - step_s;
    fill_s     = ~({WIDTH{1'b1}} >> step_s);
    work_nxt_s = res_data;
    case (op_r)
      2'b00:   work_nxt_s = res_data << step_s;
      2'b01:   work_nxt_s = res_data >> step_s;
      2'b10:   work_nxt_s = (res_data >> step_s) | (sign_r ? fill_s : {WIDTH{1'b0}});
      default: work_nxt_s = res_data;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = SHIFT;
        else          state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (rem_nxt_s == {REM_W{1'b0}}) state_nxt_s = DONE;
        else                            state_nxt_s = SHIFT;
      end
      DONE: begin
        if (res_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, iterative shift datapath and result bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data     <= {WIDTH{1'b0}};
      op_r         <= 2'b00;
      sign_r       <= 1'b0;
      rem_r        <= {REM_W{1'b0}};
      res_id       <= 1'b0;
      last_grant_r <= 1'b1;
      res_valid    <= 1'b0;
      done_cnt     <= 8'd0;
    end else begin
      res_valid <= (state_nxt_s == DONE);
      if (accept_s) begin
        res_data     <= sel_data_s;
        op_r         <= sel_op_s;
        sign_r       <= sel_data_s[WIDTH-1];
        rem_r        <= eff_s;
        res_id       <= grant_s;
        last_grant_r <= grant_s;
      end else if (state_r == SHIFT) begin
        res_data <= work_nxt_s;
        rem_r    <= rem_nxt_s;
      end else begin
        res_data <= res_data;
      end
      if (res_hs_s) begin
        done_cnt <= done_cnt + 8'd1;
      end else begin
        done_cnt <= done_cnt;
      end
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Scoreboard bench for shift_sched: randomized and directed requests, a behavioural
// reference model predicts results, grants, latency and the completion counter.
module tb_shift_sched;

  localparam int W    = 8;
  localparam int AW   = 36;
  localparam int STEP = 4;

  logic          clk;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [W-1:0]  a_data, b_data;
  logic [AW-1:0] a_amt, b_amt;
  logic [1:0]    a_op, b_op;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_data;
  logic          res_id;
  logic [7:0]    done_cnt;

  shift_sched #(.WIDTH(W), .AMT_W(AW), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt), .b_op(b_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .done_cnt(done_cnt)
  );

  typedef struct {
    bit         id;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         hold_low = 0;
  bit         busy = 0;
  bit         last_m = 1;
  int         done_m = 0;
  bit         prev_valid = 0, prev_ready = 0, prev_id = 0;
  logic [7:0] prev_data = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: shift by the whole clamped amount at once
  function automatic logic [7:0] ref_res(input logic [7:0] d, input logic [35:0] amt, input logic [1:0] op);
    longint unsigned a = amt;
    int k;
    logic signed [7:0] sd;
    if (op == 2'd3) return d;
    if (a >= W) return (op == 2'd2 && d[7]) ? 8'hFF : 8'h00;
    k = int'(a);
    sd = d;
    case (op)
      2'd0:    return d << k;
      2'd1:    return d >> k;
      default: return 8'(sd >>> k);
    endcase
  endfunction

  function automatic int ref_cycles(input logic [35:0] amt, input logic [1:0] op);
    longint unsigned a = amt;
    int eff, n;
    if (op == 2'd3) eff = 0;
    else if (a >= W) eff = W;
    else eff = int'(a);
    n = (eff + STEP - 1) / STEP;
    return (n < 1) ? 1 : n;
  endfunction

  function automatic logic [35:0] rand_amt();
    logic [63:0] r;
    case ($urandom_range(0, 3))
      0:       return 36'($urandom_range(0, W + 1));
      1:       begin r = {$urandom, $urandom}; return r[35:0]; end
      2:       begin r = 64'd1 << $urandom_range(3, 35); return r[35:0]; end
      default: return 36'hF_FFFF_FFFF;
    endcase
  endfunction

  // Monitor: models grant/busy/counter, records acceptances, checks results
  always @(negedge clk) begin
    bit   win, exp_a, exp_b, id;
    int   n;
    exp_t e;
    if (!rst_n) begin
      chk("reset_outputs", {res_valid, res_id, a_ready, b_ready, res_data, done_cnt}, 64'd0);
      exp_q.delete();
      busy = 0; last_m = 1; done_m = 0; prev_valid = 0; prev_ready = 0;
    end else begin
      if (prev_valid && prev_ready) begin
        busy = 0;
        done_m = (done_m + 1) % 256;
      end
      chk("done_cnt", done_cnt, done_m);
      win = (a_valid && b_valid) ? ~last_m : b_valid;
      exp_a = !busy && a_valid && !win;
      exp_b = !busy && b_valid && win;
      chk("a_ready", a_ready, exp_a);
      chk("b_ready", b_ready, exp_b);
      if (a_ready || b_ready) begin
        id = b_ready;
        e.id = id;
        if (id) begin
          e.data = ref_res(b_data, b_amt, b_op);
          n = ref_cycles(b_amt, b_op);
        end else begin
          e.data = ref_res(a_data, a_amt, a_op);
          n = ref_cycles(a_amt, a_op);
        end
        e.due = cyc + 1 + n;
        exp_q.push_back(e);
        busy = 1;
        last_m = id;
      end
      if (res_valid && (!prev_valid || prev_ready)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stale_result actual=%0h required=none (cycle %0d)", res_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", res_data, e.data);
          chk("res_id", res_id, e.id);
          chk("latency", cyc, e.due);
        end
      end else if (prev_valid && !prev_ready) begin
        chk("hold_valid", res_valid, 1'b1);
        chk("hold_data", res_data, prev_data);
        chk("hold_id", res_id, prev_id);
      end
      prev_valid = res_valid;
      prev_ready = res_ready;
      prev_data  = res_data;
      prev_id    = res_id;
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic run_req(input bit who, input logic [7:0] d, input logic [35:0] amt, input logic [1:0] op);
    bit got = 0;
    if (who) begin b_valid = 1'b1; b_data = d; b_amt = amt; b_op = op; end
    else     begin a_valid = 1'b1; a_data = d; a_amt = amt; a_op = op; end
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = who ? b_ready : a_ready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual=no_ready required=ready requester=%0d", who);
    end
    @(posedge clk);
    #1;
    if (who) b_valid = 1'b0;
    else     a_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  bit         dw[11] = '{0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
  logic [7:0] dd[11] = '{8'h03, 8'h83, 8'hB4, 8'hB4, 8'h0F, 8'h5A, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81};
  logic [35:0] da[11] = '{36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'd3, 36'd5, 36'd4, 36'd9,
                          36'd7, 36'd8, 36'h1_0000_0000, 36'd8, 36'd0};
  logic [1:0] dop[11] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2};

  initial begin
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = 8'h00; a_amt = 36'd0; a_op = 2'd0;
    b_valid = 1'b0; b_data = 8'h00; b_amt = 36'd0; b_op = 2'd0;
    #3;
    chk("por_outputs", {res_valid, res_id, a_ready, b_ready, res_data, done_cnt}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_req(dw[i], dd[i], da[i], dop[i]);
    drain();

    fork
      for (int i = 0; i < 2; i++) run_req(1'b0, 8'($urandom), rand_amt(), 2'($urandom));
      for (int i = 0; i < 2; i++) run_req(1'b1, 8'($urandom), rand_amt(), 2'($urandom));
    join
    drain();

    hold_low = 1'b1;
    run_req(1'b0, 8'hC3, 36'd6, 2'd2);
    for (int t = 0; t < 20 && !res_valid; t++) @(negedge clk);
    fork
      run_req(1'b1, 8'h96, 36'd2, 2'd0);
    join_none
    repeat (10) @(posedge clk);
    #1 hold_low = 1'b0;
    wait fork;
    drain();

    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 run_req(1'b0, 8'($urandom), rand_amt(), 2'($urandom));
      end
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 run_req(1'b1, 8'($urandom), rand_amt(), 2'($urandom));
      end
    join
    drain();

    run_req(1'b0, 8'h81, 36'd8, 2'd2);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {res_valid, res_id, a_ready, b_ready, res_data, done_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    fork
      run_req(1'b0, 8'h3C, 36'd1, 2'd1);
      run_req(1'b1, 8'hF0, 36'd2, 2'd2);
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
# shift_sched

Shared-shifter scheduler: arbitrates two requesters onto one iterative shift unit of `WIDTH` bits, accepting shift amounts far wider than the data (`AMT_W` bits). The scheduler clamps oversized amounts so that the result is correct: arithmetic right shift saturates to the sign fill, and the logical shifts saturate to zero. It then sequences the shift over multiple cycles, at most `STEP` bits per cycle, and returns tagged results through a valid/ready port. It sits between the operand-producing stages and the shared shift datapath.

## Interface
- `WIDTH`, 8: data width in bits, ≥2.
- `AMT_W`, 36: shift-amount width in bits; may exceed `WIDTH` by any margin.
- `STEP`, 4: maximum bits shifted per cycle, 1..`WIDTH`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `a_valid` in 1, `a_ready` out 1: requester A handshake.
- `a_data` in `WIDTH`, `a_amt` in `AMT_W` (unsigned), `a_op` in 2: requester A operands.
- `b_valid`, `b_ready`, `b_data`, `b_amt`, `b_op`: requester B, same shapes as A.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out `WIDTH`: shifted value.
- `res_id` out 1: 0 = A, 1 = B.
- `done_cnt` out 8: completed-result counter, wraps 255→0.
- Op encoding:
  - 00 = LSL
  - 01 = LSR
  - 10 = ASR (`data` is treated as signed)
  - 11 = pass-through: `res_data` = `data`, shift amount ignored.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - Grant is combinational. One valid requester wins. If both are valid, the requester not granted last time wins. `last_grant` resets to B, so A wins the first tie.
  - `x_ready` = (state==IDLE) & grant==x. At most one ready is high, and never without its valid.
  - On handshake: capture data and op; set `res_id` = grant; update `last_grant`; go to SHIFT.
  - Effective amount `eff` = (amt ≥ `WIDTH`) ? `WIDTH` : amt. The full `AMT_W`-bit compare is done at the capture edge. Never truncate amt before comparing, so 36'hF_FFFF_FFFF gives `eff` = `WIDTH`.
  - For op 11, `eff` = 0.
  - Capture `rem` = `eff`, a register of width clog2(`WIDTH`+1).
- **SHIFT**
  - Each cycle: `s` = min(`rem`, `STEP`). Shift the working register by `s` according to op. ASR fills with the captured sign bit; LSL and LSR fill with 0.
  - `rem` ← `rem` − `s`. When the new `rem` is 0, go to DONE.
  - SHIFT always occupies at least one cycle, even when `eff`=0.
- **DONE**
  - `res_valid`=1. `res_data` and `res_id` stay stable until `res_ready`.
  - On handshake: increment `done_cnt` and go to IDLE.
- Saturation results:
  - ASR by ≥`WIDTH`: all bits equal the sign bit.
  - LSL or LSR by ≥`WIDTH`: 0.
- Reset, asserted any time including mid-SHIFT or in DONE:
  - state → IDLE
  - `res_valid`, `res_data`, `res_id`, `done_cnt`, `a_ready`, `b_ready` all → 0
  - `last_grant` → B
  - any in-flight operation is dropped, with no result.

## Timing
- Acceptance edge is cycle 0. SHIFT occupies cycles 1..N, where N = max(1, ceil(`eff`/`STEP`)). `res_valid` rises at cycle N+1.
- Examples with the default parameters:
  - `eff`=8 → N=2
  - `eff`=5 → N=2
  - `eff`=0 → N=1
- `res_valid` is registered. `a_ready` and `b_ready` are combinational from state and valids, with no combinational path from `res_ready`.
- Throughput: one operation per N+2 cycles minimum. A new request is accepted the cycle after the DONE handshake, not in the same cycle.
- A requester's valid dropping while not ready: allowed, and no state change results. Operands are sampled only on the handshake edge.
- `res_ready` held low: the scheduler stays in DONE indefinitely. Both ready outputs stay 0.

## Test plan
- ASR saturation: A sends `data`=8'h03, op=10, amt=36'hF_FFFF_FFFF → `res_data`=8'h00, `res_id`=0, `res_valid` at cycle 3. Repeat with `data`=8'h83 → 8'hFF.
- Non-saturating shifts:
  - B sends 8'hB4, ASR by 3 → 8'hF6, N=1.
  - 8'hB4, LSR by 5 → 8'h05, N=2.
  - 8'h0F, LSL by 4 → 8'hF0.
  - 8'h5A, op 11, amt 9 → 8'h5A.
- Amount boundaries, 8'h81 ASR:
  - amt 7 → 8'hFF
  - amt 8 → 8'hFF
  - amt 36'h1_0000_0000 → 8'hFF; the truncated low bits are 0, but the result must still saturate.
  - LSL by amt 8 → 8'h00
  - amt 0 → 8'h81 with N=1.
- Arbitration: A and B valid continuously for 4 operations → grants A, B, A, B, and `res_id` matches each. `done_cnt` reads 4 afterwards.
- Backpressure: `res_ready` low for 10 cycles in DONE → `res_valid` and `res_data` stable, `a_ready` and `b_ready` = 0 throughout. Release → one handshake; `done_cnt` increments by exactly 1.
- Reset mid-SHIFT (amt 8, `rst_n` low at cycle 1):
  - all outputs 0 immediately, asynchronously
  - after release, no stale result appears
  - the next tie grants A, and `done_cnt` = 0.
